// File: rtl/branch_redirect_ctrl.sv
// Sequences the PC stage's control inputs: registered redirect arbitration, stall merge, and a
// small FIFO that serialises two branch-unit resolutions into the one-per-cycle predictor port.
module branch_redirect_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned GHR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_target,
    input  logic              bu0_valid,
    input  logic              bu0_mispredict,
    input  logic              bu0_is_jump,
    input  logic              bu0_is_taken,
    input  logic [GHR_W-1:0]  bu0_pht_index,
    input  logic [ADDR_W-1:0] bu0_pc,
    input  logic [ADDR_W-1:0] bu0_target,
    input  logic              bu1_valid,
    input  logic              bu1_mispredict,
    input  logic              bu1_is_jump,
    input  logic              bu1_is_taken,
    input  logic [GHR_W-1:0]  bu1_pht_index,
    input  logic [ADDR_W-1:0] bu1_pc,
    input  logic [ADDR_W-1:0] bu1_target,
    output logic              bu_ready,
    input  logic              icache_stall,
    input  logic              backend_stall,
    output logic              flush,
    output logic [ADDR_W-1:0] exc_pc,
    output logic              stall,
    output logic              is_branch_in,
    output logic              is_jump_in,
    output logic              is_taken_in,
    output logic [GHR_W-1:0]  last_pht_index,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] target_in
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              is_jump;
        logic              is_taken;
        logic [GHR_W-1:0]  pht_index;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] target;
    } entry_t;

    entry_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx1;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              flush_q, flush_d;
    logic [ADDR_W-1:0] exc_pc_q, exc_pc_d;
    logic              accept, push0, push1, pop, fifo_empty;
    entry_t            entry0, entry1, head;

    assign bu_ready   = (count_q <= CNT_W'(FIFO_DEPTH - 2)) && !rst;
    assign stall      = (icache_stall | backend_stall) & ~flush_q;
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && !stall;

    // Branch inputs are wrong-path during a flush cycle and are void when an exception clears.
    assign accept = bu_ready && !flush_q && !exc_valid;
    assign push0  = accept && bu0_valid;
    assign push1  = accept && bu1_valid && !(bu0_valid && bu0_mispredict);

    assign entry0 = '{is_jump: bu0_is_jump, is_taken: bu0_is_taken, pht_index: bu0_pht_index,
                      pc: bu0_pc, target: bu0_target};
    assign entry1 = '{is_jump: bu1_is_jump, is_taken: bu1_is_taken, pht_index: bu1_pht_index,
                      pc: bu1_pc, target: bu1_target};
    assign wr_idx1 = push0 ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

    always_comb begin
        flush_d  = 1'b0;
        exc_pc_d = exc_pc_q;
        if (exc_valid) begin
            flush_d  = 1'b1;
            exc_pc_d = exc_target;
        end else if (!flush_q) begin
            if (bu0_valid && bu0_mispredict) begin
                flush_d  = 1'b1;
                exc_pc_d = bu0_target;
            end else if (bu1_valid && bu1_mispredict) begin
                flush_d  = 1'b1;
                exc_pc_d = bu1_target;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (exc_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q  <= 1'b0;
            exc_pc_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            flush_q  <= flush_d;
            exc_pc_q <= exc_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push0) mem_q[wr_ptr_q] <= entry0;
        if (push1) mem_q[wr_idx1] <= entry1;
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        is_branch_in   = 1'b0;
        is_jump_in     = 1'b0;
        is_taken_in    = 1'b0;
        last_pht_index = '0;
        inst_pc        = '0;
        target_in      = '0;
        if (!fifo_empty) begin
            is_branch_in   = 1'b1;
            is_jump_in     = head.is_jump;
            is_taken_in    = head.is_taken;
            last_pht_index = head.pht_index;
            inst_pc        = head.pc;
            target_in      = head.target;
        end
    end

    assign flush  = flush_q;
    assign exc_pc = exc_pc_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: per-cycle vector table with a queue scoreboard
// for the predictor-update port, plus reset sequences.
module tb_branch_redirect_ctrl;

    localparam int AW = 32;
    localparam int GW = 8;

    typedef struct packed {
        logic          jmp;
        logic          tkn;
        logic [GW-1:0] pht;
        logic [AW-1:0] pc;
        logic [AW-1:0] tgt;
    } upd_t;

    typedef struct packed {
        logic          exc_v;
        logic [AW-1:0] exc_t;
        logic          v0, m0, v1, m1;
        upd_t          b0, b1;
        logic          ics, bes;
        logic          e_flush;
        logic [AW-1:0] e_pc;
        logic          e_stall, e_ready;
        logic          en0, en1, clr;
    } row_t;

    logic clk = 1'b0;
    logic rst;
    logic exc_valid;
    logic [AW-1:0] exc_target;
    logic bu0_valid, bu0_mispredict, bu0_is_jump, bu0_is_taken;
    logic [GW-1:0] bu0_pht_index;
    logic [AW-1:0] bu0_pc, bu0_target;
    logic bu1_valid, bu1_mispredict, bu1_is_jump, bu1_is_taken;
    logic [GW-1:0] bu1_pht_index;
    logic [AW-1:0] bu1_pc, bu1_target;
    logic bu_ready, icache_stall, backend_stall, flush, stall;
    logic [AW-1:0] exc_pc, inst_pc, target_in;
    logic is_branch_in, is_jump_in, is_taken_in;
    logic [GW-1:0] last_pht_index;

    int total = 0;
    int passed = 0;
    row_t rows[$];
    upd_t sb[$];

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.FIFO_DEPTH(4), .ADDR_W(AW), .GHR_W(GW)) dut (
        .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_target(exc_target),
        .bu0_valid(bu0_valid), .bu0_mispredict(bu0_mispredict), .bu0_is_jump(bu0_is_jump),
        .bu0_is_taken(bu0_is_taken), .bu0_pht_index(bu0_pht_index), .bu0_pc(bu0_pc),
        .bu0_target(bu0_target),
        .bu1_valid(bu1_valid), .bu1_mispredict(bu1_mispredict), .bu1_is_jump(bu1_is_jump),
        .bu1_is_taken(bu1_is_taken), .bu1_pht_index(bu1_pht_index), .bu1_pc(bu1_pc),
        .bu1_target(bu1_target),
        .bu_ready(bu_ready), .icache_stall(icache_stall), .backend_stall(backend_stall),
        .flush(flush), .exc_pc(exc_pc), .stall(stall), .is_branch_in(is_branch_in),
        .is_jump_in(is_jump_in), .is_taken_in(is_taken_in), .last_pht_index(last_pht_index),
        .inst_pc(inst_pc), .target_in(target_in)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic upd_t u(logic jmp, logic tkn, logic [GW-1:0] pht, logic [AW-1:0] pc,
                               logic [AW-1:0] tgt);
        upd_t e;
        e.jmp = jmp; e.tkn = tkn; e.pht = pht; e.pc = pc; e.tgt = tgt;
        return e;
    endfunction

    function automatic row_t mk(logic f, logic [AW-1:0] pc, logic st, logic rdy);
        row_t r;
        r = '0;
        r.e_flush = f; r.e_pc = pc; r.e_stall = st; r.e_ready = rdy;
        return r;
    endfunction

    task automatic drive(input row_t r);
        exc_valid = r.exc_v; exc_target = r.exc_t;
        bu0_valid = r.v0; bu0_mispredict = r.m0; bu0_is_jump = r.b0.jmp;
        bu0_is_taken = r.b0.tkn; bu0_pht_index = r.b0.pht; bu0_pc = r.b0.pc;
        bu0_target = r.b0.tgt;
        bu1_valid = r.v1; bu1_mispredict = r.m1; bu1_is_jump = r.b1.jmp;
        bu1_is_taken = r.b1.tkn; bu1_pht_index = r.b1.pht; bu1_pc = r.b1.pc;
        bu1_target = r.b1.tgt;
        icache_stall = r.ics; backend_stall = r.bes;
    endtask

    function automatic logic [127:0] head_act();
        return 128'({is_branch_in, is_jump_in, is_taken_in, last_pht_index, inst_pc, target_in});
    endfunction

    function automatic logic [127:0] head_exp();
        if (sb.size() == 0) return '0;
        return 128'({1'b1, sb[0]});
    endfunction

    task automatic build_rows();
        row_t r;
        // 0: bu0 mispredict redirect
        r = mk(0, 32'h0, 0, 1); r.v0 = 1; r.m0 = 1;
        r.b0 = u(0, 1, 8'h05, 32'hbfc00010, 32'hbfc00000); r.en0 = 1; rows.push_back(r);
        // 1-2: flush for one cycle, head visible then popped
        rows.push_back(mk(1, 32'hbfc00000, 0, 1));
        rows.push_back(mk(0, 32'hbfc00000, 0, 1));
        // 3: exception beats bu1 mispredict; bu inputs discarded
        r = mk(0, 32'hbfc00000, 0, 1); r.exc_v = 1; r.exc_t = 32'hbfc00380; r.clr = 1;
        r.v0 = 1; r.b0 = u(0, 0, 8'h01, 32'h80000004, 32'h80000008);
        r.v1 = 1; r.m1 = 1; r.b1 = u(0, 1, 8'h02, 32'h80000000, 32'h80000100);
        rows.push_back(r);
        rows.push_back(mk(1, 32'hbfc00380, 0, 1));
        // 5: bu0 mispredict drops younger bu1
        r = mk(0, 32'hbfc00380, 0, 1); r.v0 = 1; r.m0 = 1; r.en0 = 1;
        r.b0 = u(0, 1, 8'h11, 32'h80001000, 32'h80002000);
        r.v1 = 1; r.b1 = u(0, 0, 8'h12, 32'h80001004, 32'h80001008); rows.push_back(r);
        // 6: flush cycle ignores bu inputs; flush overrides backend_stall
        r = mk(1, 32'h80002000, 0, 1); r.bes = 1; r.v0 = 1; r.m0 = 1;
        r.b0 = u(0, 1, 8'h13, 32'h90000000, 32'h90000100);
        r.v1 = 1; r.b1 = u(0, 0, 8'h14, 32'h90000004, 32'h90000008); rows.push_back(r);
        r = mk(0, 32'h80002000, 1, 1); r.bes = 1; rows.push_back(r);
        // 8-10: fill under icache stall until bu_ready drops
        r = mk(0, 32'h80002000, 1, 1); r.ics = 1; r.v0 = 1; r.en0 = 1;
        r.b0 = u(0, 0, 8'h21, 32'ha0000000, 32'ha0000004); rows.push_back(r);
        r = mk(0, 32'h80002000, 1, 1); r.ics = 1; r.v0 = 1; r.v1 = 1; r.en0 = 1; r.en1 = 1;
        r.b0 = u(1, 1, 8'h22, 32'ha0000010, 32'ha0000100);
        r.b1 = u(0, 1, 8'h23, 32'ha0000020, 32'ha0000200); rows.push_back(r);
        r = mk(0, 32'h80002000, 1, 0); r.ics = 1; r.v0 = 1;
        r.b0 = u(0, 0, 8'h31, 32'ha0000040, 32'ha0000044); rows.push_back(r);
        // 11: stall released, held bu0 still refused while full
        r = mk(0, 32'h80002000, 0, 0); r.v0 = 1;
        r.b0 = u(0, 0, 8'h31, 32'ha0000040, 32'ha0000044); rows.push_back(r);
        // 12: pop plus two pushes at count = depth-2
        r = mk(0, 32'h80002000, 0, 1); r.v0 = 1; r.v1 = 1; r.en0 = 1; r.en1 = 1;
        r.b0 = u(0, 0, 8'h31, 32'ha0000040, 32'ha0000044);
        r.b1 = u(1, 1, 8'h32, 32'ha0000050, 32'ha0000500); rows.push_back(r);
        rows.push_back(mk(0, 32'h80002000, 0, 0));
        rows.push_back(mk(0, 32'h80002000, 0, 1));
        rows.push_back(mk(0, 32'h80002000, 0, 1));
        rows.push_back(mk(0, 32'h80002000, 0, 1));
        // 17: bu1-only mispredict
        r = mk(0, 32'h80002000, 0, 1); r.v1 = 1; r.m1 = 1; r.en1 = 1;
        r.b1 = u(0, 1, 8'h33, 32'hb0000000, 32'hb0000040); rows.push_back(r);
        rows.push_back(mk(1, 32'hb0000040, 0, 1));
        rows.push_back(mk(0, 32'hb0000040, 0, 1));
        // 20-23: back-to-back exceptions
        r = mk(0, 32'hb0000040, 0, 1); r.exc_v = 1; r.exc_t = 32'hbfc00380; r.clr = 1;
        rows.push_back(r);
        r = mk(1, 32'hbfc00380, 0, 1); r.exc_v = 1; r.exc_t = 32'hbfc00400; r.clr = 1;
        rows.push_back(r);
        rows.push_back(mk(1, 32'hbfc00400, 0, 1));
        rows.push_back(mk(0, 32'hbfc00400, 0, 1));
    endtask

    initial begin
        row_t idle;
        idle = '0;
        drive(idle);
        rst = 1'b1;
        build_rows();
        @(posedge clk);
        @(negedge clk);
        check("reset bu_ready", 128'(bu_ready), 128'(0));
        check("reset flush", 128'(flush), 128'(0));
        check("reset exc_pc", 128'(exc_pc), 128'(0));
        check("reset update port", head_act(), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d outputs", i),
                  128'({flush, exc_pc, stall, head_act()}), 128'(0));
            check($sformatf("idle%0d bu_ready", i), 128'(bu_ready), 128'(1));
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            @(negedge clk);
            check($sformatf("row%0d flush", i), 128'(flush), 128'(rows[i].e_flush));
            check($sformatf("row%0d exc_pc", i), 128'(exc_pc), 128'(rows[i].e_pc));
            check($sformatf("row%0d stall", i), 128'(stall), 128'(rows[i].e_stall));
            check($sformatf("row%0d bu_ready", i), 128'(bu_ready), 128'(rows[i].e_ready));
            check($sformatf("row%0d head", i), head_act(), head_exp());
            if (sb.size() > 0 && !rows[i].e_stall) void'(sb.pop_front());
            if (rows[i].clr) sb.delete();
            if (rows[i].en0) sb.push_back(rows[i].b0);
            if (rows[i].en1) sb.push_back(rows[i].b1);
            @(posedge clk);
            #1;
        end

        // Mid-operation reset: held FIFO entry and a pending mispredict are both discarded.
        idle.ics = 1; idle.v0 = 1; idle.b0 = u(0, 0, 8'h41, 32'hc0000000, 32'hc0000004);
        drive(idle);
        @(posedge clk);
        #1 rst = 1'b1;
        idle.ics = 0; idle.m0 = 1; idle.b0 = u(0, 1, 8'h42, 32'hc0000010, 32'hc0000100);
        drive(idle);
        @(negedge clk);
        check("midreset bu_ready", 128'(bu_ready), 128'(0));
        check("midreset head held", 128'(inst_pc), 128'(32'hc0000000));
        @(posedge clk);
        #1 rst = 1'b0;
        idle = '0;
        drive(idle);
        @(negedge clk);
        check("postreset flush", 128'(flush), 128'(0));
        check("postreset exc_pc", 128'(exc_pc), 128'(0));
        check("postreset update port", head_act(), 128'(0));
        check("postreset bu_ready", 128'(bu_ready), 128'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences the PC stage's control inputs: arbitrates exception and branch-mispredict redirects into a single registered flush/exc_pc pulse, merges fetch and backend stall requests, and serialises branch-resolution updates from two branch units into the one-per-cycle predictor update port of the PC stage through a small FIFO. Sits between the branch units and commit logic on one side and the PC stage and PCIF register on the other.

## Interface
- FIFO_DEPTH, 4, predictor-update FIFO entries; power of two, ≥ 2
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- exc_valid  in  1  commit raises exception/eret redirect
- exc_target  in  `ADDR_BUS  exception redirect address
- bu0_valid, bu1_valid  in  1  branch resolved on port 0/1; port 0 is always older than port 1
- buN_mispredict  in  1  prediction wrong; redirect required
- buN_is_jump, buN_is_taken  in  1  resolved branch kind/outcome
- buN_pht_index  in  `GHR_BUS  PHT index carried from fetch
- buN_pc, buN_target  in  `ADDR_BUS  branch PC; correct next PC (taken target or fall-through)
- bu_ready  out  1  both ports may present this cycle
- icache_stall, backend_stall  in  1  stall requests
- flush  out  1  to PC stage and PCIF
- exc_pc  out  `ADDR_BUS  redirect PC, valid while flush = 1
- stall  out  1  to PC stage and PCIF
- is_branch_in, is_jump_in, is_taken_in  out  1  predictor update
- last_pht_index  out  `GHR_BUS  update PHT index
- inst_pc, target_in  out  `ADDR_BUS  update PC / target

## Operation
- Redirect arbitration, evaluated in cycle N and registered into flush/exc_pc for cycle N+1:
  - exc_valid wins: exc_pc ← exc_target.
  - Otherwise bu0 valid and mispredict wins: exc_pc ← bu0_target.
  - Otherwise bu1 valid and mispredict: exc_pc ← bu1_target.
  - Otherwise flush ← 0 and exc_pc holds its last value.
- Wrong-path squash: in any cycle where flush = 1, bu0/bu1 inputs are ignored (not enqueued, no redirect). exc_valid is still honoured and produces a back-to-back flush.
- FIFO enqueue of accepted branches (valid, bu_ready = 1, flush = 0, no exc_valid this cycle):
  - Port 0 is written before port 1.
  - When bu0 mispredicts, bu1 is dropped because it is younger.
  - Mispredicting branches themselves are enqueued, so the predictor learns.
- exc_valid in cycle N clears the FIFO at the N→N+1 edge. Bu inputs in cycle N are discarded.
- bu_ready = (count ≤ FIFO_DEPTH−2) && !rst, computed from registered count. When bu_ready = 0, branch units hold their inputs; nothing is enqueued.
- Dequeue: the head drives is_branch_in = 1 plus its fields. It pops when stall = 0. While stall = 1 the head is held with is_branch_in still asserted, and the PC stage ignores it. When the FIFO is empty, all update outputs are 0.
- stall = (icache_stall | backend_stall) & !flush. Flush overrides stall so the PC loads exc_pc.
- Count arithmetic: pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. count = 0..FIFO_DEPTH. A pop and up to two pushes may occur in the same cycle.

## Timing
- Reset values: flush 0, exc_pc 0, FIFO empty (count 0, pointers 0), is_branch_in/is_jump_in/is_taken_in 0, last_pht_index 0, inst_pc 0, target_in 0, bu_ready 0 during rst. stall follows its equation.
- Reset mid-operation discards any pending redirect and all FIFO contents on the next edge.
- Redirect latency: event in cycle N → flush = 1 for exactly cycle N+1, unless another qualifying exc_valid occurs in N+1.
- Update latency: enqueue in cycle N → earliest visible at the head in N+1, one pop per unstalled cycle.
- stall is combinational from its inputs and the registered flush. No registered path.
- Simultaneous pop and two pushes at count = FIFO_DEPTH−2 is legal; the FIFO becomes FIFO_DEPTH−1.

## Test plan
- Reset then idle for 10 cycles → all outputs 0, bu_ready = 1.
- bu0 mispredict, pc 0xbfc00010, target 0xbfc00000, pht 0x5 at N → flush = 1 and exc_pc = 0xbfc00000 in N+1 only. Update head is pc 0xbfc00010, is_taken 1, pht 0x5 in N+1.
- exc_valid (target 0xbfc00380) together with bu1 mispredict (target 0x80000100) at N → exc_pc = 0xbfc00380, FIFO empty in N+1, no update issued.
- bu0 mispredict and bu1 valid in the same cycle → only bu0 enqueued (count = 1). Bu inputs presented in the flush cycle → count unchanged.
- Hold icache_stall = 1 while enqueuing 2 branches per cycle → count reaches 3, bu_ready = 0. Head is held with stall = 1. Release stall → one pop per cycle, entries drain in port-0-first order.
- backend_stall = 1 when flush asserts → stall = 0 in the flush cycle, stall = 1 the following cycle.
